// File: rtl/prio_enc_rr.sv
// Registered priority encoder with fixed-priority and round-robin selection.
// Output holds under backpressure; ptr remembers the last accepted index.
`timescale 1ns/1ps
module prio_enc_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i,
  input  logic         mode,
  input  logic         ready,
  output logic [W-1:0] y,
  output logic         valid,
  output logic         multi
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state, state_n;
  logic [W-1:0] ptr, ptr_n;
  logic [W-1:0] y_n;
  logic         multi_n;
  logic [W-1:0] base;
  logic [W-1:0] sel_fp, sel_rr;
  logic         hs, load, many;

  function automatic logic [W-1:0] pick_fp(
    input logic [N-1:0] r
  );
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++)
      if (r[k]) s = W'(k);
    return s;
  endfunction

  // Search starts one past base and wraps, so base itself is tried last.
  function automatic logic [W-1:0] pick_rr(
    input logic [N-1:0] r,
    input logic [W-1:0] b
  );
    logic [W-1:0] s;
    logic         found;
    int           idx;
    s     = b;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(b) + 1 + k) % N;
      if (!found && r[idx[W-1:0]]) begin
        s     = idx[W-1:0];
        found = 1'b1;
      end
    end
    return s;
  endfunction

  assign valid  = (state == FULL);
  assign hs     = valid && ready;
  assign load   = !valid || hs;
  assign base   = hs ? y : ptr;
  assign many   = |(i & (i - {{(N-1){1'b0}}, 1'b1}));
  assign sel_fp = pick_fp(i);
  assign sel_rr = pick_rr(i, base);

  always_comb begin
    state_n = state;
    y_n     = y;
    multi_n = multi;
    ptr_n   = hs ? y : ptr;
    if (load) begin
      if (|i) begin
        state_n = FULL;
        y_n     = mode ? sel_rr : sel_fp;
        multi_n = many;
      end else begin
        state_n = EMPTY;
        multi_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      y     <= '0;
      multi <= 1'b0;
      ptr   <= W'(N - 1);
    end else begin
      state <= state_n;
      y     <= y_n;
      multi <= multi_n;
      ptr   <= ptr_n;
    end
  end

endmodule

// File: tb/tb_prio_enc_rr.sv
// Directed-vector bench for prio_enc_rr at N=8.
`timescale 1ns/1ps
module tb_prio_enc_rr;

  logic       clk;
  logic       rst_n;
  logic [7:0] i;
  logic       mode;
  logic       ready;
  logic [2:0] y;
  logic       valid;
  logic       multi;

  int checks = 0;
  int errors = 0;

  prio_enc_rr #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .mode  (mode),
    .ready (ready),
    .y     (y),
    .valid (valid),
    .multi (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int rr_exp [5] = '{0, 2, 7, 0, 2};
    rst_n = 1'b1;
    i     = '0;
    mode  = 1'b0;
    ready = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_y", 32'(y), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_multi", 32'(multi), 0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    i     = '0;
    ready = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 32'(valid), 0);

    i = 8'b0100_0100;
    @(negedge clk);
    chk("fp_y6", 32'(y), 6);
    chk("fp_v6", 32'(valid), 1);
    chk("fp_m6", 32'(multi), 1);

    i = 8'b0000_0001;
    @(negedge clk);
    chk("fp_y0", 32'(y), 0);
    chk("fp_m0", 32'(multi), 0);

    i = 8'b0100_0100;
    @(negedge clk);
    chk("bp_pre_y", 32'(y), 6);

    ready = 1'b0;
    i     = 8'b0000_0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_y", 32'(y), 6);
      chk("bp_hold_v", 32'(valid), 1);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_y", 32'(y), 1);
    chk("bp_rel_m", 32'(multi), 0);

    i = 8'b1000_0000;
    @(negedge clk);
    chk("pre_rr_y7", 32'(y), 7);

    mode = 1'b1;
    i    = 8'b1000_0101;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rr_y", 32'(y), 32'(rr_exp[c]));
      chk("rr_m", 32'(multi), 1);
    end

    i = '0;
    @(negedge clk);
    chk("idle_v", 32'(valid), 0);
    chk("idle_y", 32'(y), 2);
    chk("idle_m", 32'(multi), 0);

    i = 8'b0000_1000;
    @(negedge clk);
    chk("idle_next_y", 32'(y), 3);
    chk("idle_next_v", 32'(valid), 1);

    @(negedge clk);
    chk("full_wrap_y", 32'(y), 3);

    ready = 1'b0;
    mode  = 1'b0;
    i     = 8'b1000_0001;
    @(negedge clk);
    chk("mode_hold_y", 32'(y), 3);
    chk("mode_hold_m", 32'(multi), 0);
    ready = 1'b1;
    @(negedge clk);
    chk("mode_new_y", 32'(y), 7);
    chk("mode_new_m", 32'(multi), 1);

    ready = 1'b0;
    i     = '0;
    @(negedge clk);
    chk("ar_pre_y", 32'(y), 7);
    chk("ar_pre_v", 32'(valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_v", 32'(valid), 0);
    chk("ar_y", 32'(y), 0);
    chk("ar_m", 32'(multi), 0);

    @(negedge clk);
    rst_n = 1'b1;
    mode  = 1'b1;
    ready = 1'b1;
    i     = 8'b1000_0001;
    @(negedge clk);
    chk("ar_rr_y", 32'(y), 0);
    chk("ar_rr_v", 32'(valid), 1);
    chk("ar_rr_m", 32'(multi), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prio_enc_rr.md
PRIO_ENC_RR -- requirements
Module: prio_enc_rr

Interface
REQ-001 Parameter N, default 8, number of request inputs; legal range 2..64.
REQ-002 Parameter W, default $clog2(N), index width; derived, never overridden.
REQ-003 clk  input  1  single clock for all state; rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk.
REQ-005 i  input  N  request vector; bit k set = request from source k.
REQ-006 mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 ready  input  1  consumer accepts current output this cycle.
REQ-008 y  output  W  encoded index of selected request, registered.
REQ-009 valid  output  1  y holds an unaccepted encoding.
REQ-010 multi  output  1  more than one bit of i was set when y was loaded, registered.

Function
REQ-011 Two states: EMPTY (valid=0) and FULL (valid=1); no other state.
REQ-012 Load condition: load = !valid || (valid && ready); evaluated every rising edge.
REQ-013 On load with i != 0: y <= selected index, multi <= (popcount(i) > 1), valid <= 1; state FULL.
REQ-014 On load with i == 0: valid <= 0, multi <= 0, y unchanged; state EMPTY.
REQ-015 No load (FULL and ready=0): y, valid, multi held; i and mode ignored.
REQ-016 Latency: request sampled at edge t appears on y/valid after edge t; one cycle.
REQ-017 mode=0 selection: highest set bit index of i.
REQ-018 mode=1 selection: first set bit found searching upward from (base+1) mod N, wrapping, where base = y if (valid && ready) else ptr.
REQ-019 Internal pointer ptr (W bits) <= y on every handshake (valid && ready), in both modes.
REQ-020 ptr wrap: search past index N-1 continues at 0; a single set bit equal to base is selected (full wrap).
REQ-021 mode sampled only at load; a mode change while FULL takes effect on the next load; ptr not cleared by mode change.
REQ-022 Simultaneous handshake and load: the accepted y updates ptr and serves as base for the new selection in the same edge.
REQ-023 Non-power-of-two N: y never exceeds N-1.

Reset
REQ-024 rst_n low forces, asynchronously: y=0, valid=0, multi=0, ptr=N-1 (first round-robin search starts at 0).
REQ-025 Reset mid-operation (FULL, ready=0) discards the held encoding immediately; no handshake is recorded.
REQ-026 First load occurs on the first rising edge after rst_n deassertion.

Verification (N=8)
REQ-027 Reset: rst_n=0 -> y=0, valid=0, multi=0 without a clock edge; after release with i=0, valid stays 0.
REQ-028 Fixed priority: mode=0, ready=1, i=8'b0100_0100 -> next edge y=6, valid=1, multi=1; i=8'b0000_0001 -> y=0, multi=0.
REQ-029 Backpressure: FULL with y=6, ready=0, i changed to 8'b0000_0010 for 3 cycles -> y=6 held; ready=1 -> next edge y=1.
REQ-030 Round-robin: mode=1, ready=1, i=8'b1000_0101 held -> successive y = 0,2,7,0,2; multi=1 throughout.
REQ-031 Idle: ready=1, i=0 after y=2 -> next edge valid=0, y stays 2; then i=8'b0000_1000 -> y=3, valid=1.
REQ-032 Async reset while FULL (y=7, ready=0) -> valid=0 immediately; after release mode=1, i=8'b1000_0001 -> y=0.
